sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of requesters; index 0 = fill, 1 = alpha blend, 2 = display output.
REQ-002 Parameter ADDR_W, default 24: SRAM word address width.
REQ-003 Parameter DATA_W, default 1536: access width, 64 words x 24 bits.
REQ-004 Parameter ACC_CYCLES, default 1: cycles SRAM enables are held per access, legal range 1..15.
REQ-005 The block uses one clock; reset is synchronous and active-high.
REQ-006 Port clk, input, 1 bit: the system clock; all state updates on its rising edge.
REQ-007 Port n_rst, input, 1 bit: synchronous, active-high reset.
REQ-008 Port req, input, NUM_REQ bits: per-requester access request, level.
REQ-009 Port req_we, input, NUM_REQ bits: per-requester write (1) or read (0) select.
REQ-010 Port req_addr, input, NUM_REQ*ADDR_W bits: per-requester address, slice i at [i*ADDR_W +: ADDR_W].
REQ-011 Port req_wdata, input, NUM_REQ*DATA_W bits: per-requester write data, sliced the same way.
REQ-012 Port ack, output, NUM_REQ bits: one-cycle completion pulse per requester.
REQ-013 Port rdata, output, DATA_W bits: registered read data, shared by all requesters.
REQ-014 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 Port read_enable, output, 1 bit: SRAM read strobe.
REQ-016 Port write_enable, output, 1 bit: SRAM write strobe.
REQ-017 Port address, output, ADDR_W bits: SRAM address.
REQ-018 Port write_data, output, DATA_W bits: SRAM write data.
REQ-019 Port read_data, input, DATA_W bits: SRAM read data.

Function
REQ-020 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-021 IDLE, when any req bit is high: register the winner index, its we, addr and wdata, and go to ACCESS; with no request pending, stay in IDLE.
REQ-022 Arbitration SHALL be round-robin: scan from rr_ptr upward with wrap; the first set req bit wins.
REQ-023 In ACCESS, the SRAM outputs SHALL be registered copies of the latched request: read_enable = !we, write_enable = we, never both high.
REQ-024 ACCESS SHALL last exactly ACC_CYCLES cycles, counted by an internal counter, and then go to RESP.
REQ-025 On the edge leaving ACCESS for a read, rdata SHALL capture read_data; for a write, rdata SHALL hold its previous value.
REQ-026 In RESP: ack[winner] = 1 for exactly one cycle, SRAM enables = 0, rr_ptr = (winner+1) mod NUM_REQ, next state IDLE.
REQ-027 Latency: req seen in IDLE at cycle N gives enables during N+1..N+ACC_CYCLES and ack at N+ACC_CYCLES+1.
REQ-028 rdata SHALL remain stable from RESP until the next read capture.
REQ-029 A requester must deassert or change req in the cycle after its ack; req still high in IDLE is a new request.
REQ-030 A req drop during ACCESS/RESP SHALL be ignored: the access completes and ack still pulses.
REQ-031 Changes to req_addr, req_we or req_wdata after the grant SHALL have no effect on the current access.
REQ-032 The SRAM outputs SHALL be zero when not in ACCESS; address and write_data SHALL also return to 0.
REQ-033 Throughput: at most one access per ACC_CYCLES+2 cycles.

Reset
REQ-034 While n_rst = 1 at a clock edge, the block SHALL set state = IDLE, rr_ptr = 0, counter = 0, ack = 0, rdata = 0, busy = 0, read_enable = 0, write_enable = 0, address = 0 and write_data = 0.
REQ-035 A reset during ACCESS SHALL drop the SRAM enables on that edge with no ack issued; the requester re-requests.

Verification
REQ-036 Single write: req = 001, we = 1, addr = 0x000040, wdata = pattern A -> write_enable high exactly 1 cycle with address 0x000040; ack = 001 two cycles after the req cycle.
REQ-037 Read-back: req = 100, we = 0, addr = 0x000040 -> rdata = pattern A during ack = 100.
REQ-038 Contention: req = 111 held, each requester dropping its req after its ack and re-raising it the cycle after -> acks in order 001, 010, 100, 001; no two acks in the same cycle.
REQ-039 Fairness: req[0] held continuously, req[1] raised once -> the grant after the next ack[0] goes to requester 1.
REQ-040 Reset mid-access: ACC_CYCLES = 4, n_rst = 1 in the second ACCESS cycle -> enables = 0 on the next edge, no ack, busy = 0, rr_ptr = 0.
REQ-041 Stability: change req_addr during ACCESS -> SRAM address unchanged; read_enable and write_enable never both high.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one wide SRAM port
// among NUM_REQ requesters (fill, alpha blend, display output).
module sram_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 1536,
  parameter int ACC_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      read_enable,
  output logic                      write_enable,
  output logic [ADDR_W-1:0]         address,
  output logic [DATA_W-1:0]         write_data,
  input  logic [DATA_W-1:0]         read_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] CNT_LAST = 4'(ACC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] rr_ptr_d;
  logic [IDX_W-1:0] win_q;
  logic [IDX_W-1:0] win_d;
  logic [3:0]       cnt_q;
  logic [3:0]       cnt_d;
  logic             grant_vld;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand;
  logic             load;
  logic             finish;

  function automatic logic [IDX_W-1:0] wrap_idx(
    input int base,
    input int off
  );
    int s;
    s = (base + off) % NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Round-robin pick: first set req bit scanning up from rr_ptr.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = wrap_idx(int'(rr_ptr_q), i);
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Next-state, access counter and pointer update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    load     = 1'b0;
    finish   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_d = ACCESS;
          cnt_d   = '0;
          win_d   = grant_idx;
          load    = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          cnt_d   = '0;
          finish  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        state_d  = IDLE;
        rr_ptr_d = wrap_idx(int'(win_q), 1);
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
    end
  end

  // SRAM port: loaded from the winner at grant, cleared after ACCESS.
  // These registers double as the latched copy of the request.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      read_enable  <= 1'b0;
      write_enable <= 1'b0;
      address      <= '0;
      write_data   <= '0;
    end else if (load) begin
      read_enable  <= !req_we[grant_idx];
      write_enable <= req_we[grant_idx];
      address      <= req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
      write_data   <= req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
    end else if (finish) begin
      read_enable  <= 1'b0;
      write_enable <= 1'b0;
      address      <= '0;
      write_data   <= '0;
    end
  end

  // Completion pulse and read capture on the edge leaving ACCESS.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      ack   <= '0;
      rdata <= '0;
    end else begin
      ack <= finish ? (NUM_REQ'(1) << win_q) : '0;
      if (finish && read_enable) begin
        rdata <= read_data;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule
